// File: rtl/load_pkg.sv
// rtl/load_pkg.sv - opcode, error-code and state definitions shared by the load access unit.
package load_pkg;

    localparam logic [5:0] OP_LB  = 6'b100000;
    localparam logic [5:0] OP_LH  = 6'b100001;
    localparam logic [5:0] OP_LW  = 6'b100011;
    localparam logic [5:0] OP_LBU = 6'b100100;
    localparam logic [5:0] OP_LHU = 6'b100101;
    localparam logic [5:0] OP_LWU = 6'b100111;
    localparam logic [5:0] OP_LD  = 6'b110111;

    localparam logic [1:0] ERR_NONE     = 2'd0;
    localparam logic [1:0] ERR_MISALIGN = 2'd1;
    localparam logic [1:0] ERR_TIMEOUT  = 2'd2;
    localparam logic [1:0] ERR_ILLEGAL  = 2'd3;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT,
        ST_ISSUE2,
        ST_WAIT2,
        ST_RESP
    } state_t;

    function automatic logic [3:0] access_bytes(input logic [5:0] op);
        case (op)
            OP_LB, OP_LBU: access_bytes = 4'd1;
            OP_LH, OP_LHU: access_bytes = 4'd2;
            OP_LW, OP_LWU: access_bytes = 4'd4;
            OP_LD:         access_bytes = 4'd8;
            default:       access_bytes = 4'd0;
        endcase
    endfunction

    function automatic logic op_signed(input logic [5:0] op);
        op_signed = (op == OP_LB) || (op == OP_LH) || (op == OP_LW) || (op == OP_LD);
    endfunction

    function automatic logic op_legal(input logic [5:0] op, input int data_w);
        case (op)
            OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU, OP_LWU: op_legal = 1'b1;
            OP_LD:   op_legal = (data_w == 64);
            default: op_legal = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/load_extract.sv
// rtl/load_extract.sv - little-endian lane select and sign/zero extension of a load field.
module load_extract
    import load_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int OFF_W  = $clog2(DATA_W / 8)
) (
    input  logic [2*DATA_W-1:0] word,
    input  logic [OFF_W-1:0]    offset,
    input  logic [5:0]          op,
    output logic [DATA_W-1:0]   result
);

    logic [DATA_W-1:0] shifted;
    logic              msb;
    int                nbits;

    // The upper half of word carries the second read of a split access.
    always_comb begin
        shifted = DATA_W'(word >> {offset, 3'b000});
        case (access_bytes(op))
            4'd1: begin nbits = 8;  msb = shifted[7];  end
            4'd2: begin nbits = 16; msb = shifted[15]; end
            4'd4: begin nbits = 32; msb = shifted[31]; end
            default: begin nbits = DATA_W; msb = shifted[DATA_W-1]; end
        endcase
        msb = msb & op_signed(op);
        result = '0;
        for (int i = 0; i < DATA_W; i++) begin
            result[i] = (i < nbits) ? shifted[i] : msb;
        end
    end

endmodule

// File: rtl/load_access_unit.sv
// rtl/load_access_unit.sv - MEM-stage load engine; LOAD_UNALIGNED_SPLIT_EN enables split unaligned reads.
module load_access_unit
    import load_pkg::*;
#(
    parameter int DATA_W         = 32,
    parameter int ADDR_W         = 32,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [5:0]        req_op,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [4:0]        req_rd,
    output logic              mem_rd_en,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_rvalid,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_data,
    output logic [4:0]        rsp_rd,
    output logic              rsp_err,
    output logic [1:0]        rsp_err_code,
    output logic              busy
);

    localparam int BYTES = DATA_W / 8;
    localparam int OFF_W = $clog2(BYTES);
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    state_t              state;
    logic [5:0]          op_q;
    logic [OFF_W-1:0]    off_q;
    logic [4:0]          rd_q;
    logic [CNT_W-1:0]    cnt;

    logic [3:0]          req_bytes;
    logic [OFF_W-1:0]    req_off;
    logic                req_legal;
    logic                req_misaligned;
    logic                timeout_hit;
    logic [2*DATA_W-1:0] ext_word;
    logic [DATA_W-1:0]   ext_data;

`ifdef LOAD_UNALIGNED_SPLIT_EN
    logic                req_cross;
    logic                cross_q;
    logic [DATA_W-1:0]   word0_q;
`endif

    always_comb begin
        req_bytes   = access_bytes(req_op);
        req_off     = req_addr[OFF_W-1:0];
        req_legal   = op_legal(req_op, DATA_W);
        timeout_hit = (cnt == CNT_W'(TIMEOUT_CYCLES - 1));
`ifdef LOAD_UNALIGNED_SPLIT_EN
        req_misaligned = 1'b0;
        req_cross      = (int'(req_off) + int'(req_bytes)) > BYTES;
        ext_word       = (state == ST_WAIT2) ? {mem_rdata, word0_q}
                                             : {{DATA_W{1'b0}}, mem_rdata};
`else
        req_misaligned = (req_off & OFF_W'(req_bytes - 4'd1)) != '0;
        ext_word       = {{DATA_W{1'b0}}, mem_rdata};
`endif
    end

    load_extract #(.DATA_W(DATA_W)) u_extract (
        .word   (ext_word),
        .offset (off_q),
        .op     (op_q),
        .result (ext_data)
    );

    assign req_ready = (state == ST_IDLE);
    assign busy      = (state != ST_IDLE);
    assign rsp_err   = (rsp_err_code != ERR_NONE);

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= ST_IDLE;
            op_q         <= '0;
            off_q        <= '0;
            rd_q         <= '0;
            cnt          <= '0;
            mem_rd_en    <= 1'b0;
            mem_addr     <= '0;
            rsp_valid    <= 1'b0;
            rsp_data     <= '0;
            rsp_rd       <= '0;
            rsp_err_code <= ERR_NONE;
`ifdef LOAD_UNALIGNED_SPLIT_EN
            cross_q      <= 1'b0;
            word0_q      <= '0;
`endif
        end else begin
            case (state)
                ST_IDLE: begin
                    if (req_valid) begin
                        op_q  <= req_op;
                        off_q <= req_off;
                        rd_q  <= req_rd;
`ifdef LOAD_UNALIGNED_SPLIT_EN
                        cross_q <= req_cross;
`endif
                        if (!req_legal || req_misaligned) begin
                            state        <= ST_RESP;
                            rsp_valid    <= 1'b1;
                            rsp_data     <= '0;
                            rsp_rd       <= req_rd;
                            rsp_err_code <= !req_legal ? ERR_ILLEGAL : ERR_MISALIGN;
                        end else begin
                            state     <= ST_ISSUE;
                            mem_rd_en <= 1'b1;
                            mem_addr  <= {req_addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
                        end
                    end
                end
                ST_ISSUE: begin
                    mem_rd_en <= 1'b0;
                    state     <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (mem_rvalid) begin
                        cnt <= '0;
`ifdef LOAD_UNALIGNED_SPLIT_EN
                        if (cross_q) begin
                            word0_q   <= mem_rdata;
                            mem_rd_en <= 1'b1;
                            mem_addr  <= mem_addr + ADDR_W'(BYTES);
                            state     <= ST_ISSUE2;
                        end else
`endif
                        begin
                            state        <= ST_RESP;
                            rsp_valid    <= 1'b1;
                            rsp_data     <= ext_data;
                            rsp_rd       <= rd_q;
                            rsp_err_code <= ERR_NONE;
                        end
                    end else if (timeout_hit) begin
                        cnt          <= '0;
                        state        <= ST_RESP;
                        rsp_valid    <= 1'b1;
                        rsp_data     <= '0;
                        rsp_rd       <= rd_q;
                        rsp_err_code <= ERR_TIMEOUT;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
`ifdef LOAD_UNALIGNED_SPLIT_EN
                ST_ISSUE2: begin
                    mem_rd_en <= 1'b0;
                    state     <= ST_WAIT2;
                end
                ST_WAIT2: begin
                    if (mem_rvalid || timeout_hit) begin
                        cnt          <= '0;
                        state        <= ST_RESP;
                        rsp_valid    <= 1'b1;
                        rsp_data     <= mem_rvalid ? ext_data : '0;
                        rsp_rd       <= rd_q;
                        rsp_err_code <= mem_rvalid ? ERR_NONE : ERR_TIMEOUT;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
`endif
                ST_RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        state     <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_load_access_unit.sv
// tb/tb_load_access_unit.sv - scoreboard bench for load_access_unit with directed load vectors.
module tb_load_access_unit;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 32;
    localparam int TMO    = 4;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              req_valid = 1'b0;
    logic              req_ready;
    logic [5:0]        req_op = '0;
    logic [ADDR_W-1:0] req_addr = '0;
    logic [4:0]        req_rd = '0;
    logic              mem_rd_en;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_rdata = '0;
    logic              mem_rvalid = 1'b0;
    logic              rsp_valid;
    logic              rsp_ready = 1'b1;
    logic [DATA_W-1:0] rsp_data;
    logic [4:0]        rsp_rd;
    logic              rsp_err;
    logic [1:0]        rsp_err_code;
    logic              busy;

    always #5 clk = ~clk;

    load_access_unit #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .TIMEOUT_CYCLES(TMO)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
        .req_addr(req_addr), .req_rd(req_rd),
        .mem_rd_en(mem_rd_en), .mem_addr(mem_addr), .mem_rdata(mem_rdata),
        .mem_rvalid(mem_rvalid),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
        .rsp_rd(rsp_rd), .rsp_err(rsp_err), .rsp_err_code(rsp_err_code),
        .busy(busy)
    );

    typedef struct packed {
        logic [31:0] data;
        logic [4:0]  rd;
        logic [1:0]  code;
    } rsp_t;

    rsp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_rsp(input logic [31:0] data, input logic [4:0] rd, input logic [1:0] code);
        rsp_t e;
        e.data = data;
        e.rd   = rd;
        e.code = code;
        exp_q.push_back(e);
    endtask

    // Monitor: every accepted response is compared against the oldest expectation.
    always @(negedge clk) begin
        if (!reset && rsp_valid && rsp_ready) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL rsp_unexpected: got response data 0x%0h code %0d, expected none",
                         rsp_data, rsp_err_code);
            end else begin
                rsp_t e;
                e = exp_q.pop_front();
                check("rsp_data", 64'(rsp_data), 64'(e.data));
                check("rsp_rd", 64'(rsp_rd), 64'(e.rd));
                check("rsp_err_code", 64'(rsp_err_code), 64'(e.code));
                check("rsp_err", 64'(rsp_err), 64'(e.code != 2'd0));
            end
        end
    end

    task automatic issue(input logic [5:0] op, input logic [31:0] addr, input logic [4:0] rd);
        check("req_ready_idle", 64'(req_ready), 64'd1);
        req_valid = 1'b1;
        req_op    = op;
        req_addr  = addr;
        req_rd    = rd;
        tick();
        req_valid = 1'b0;
    endtask

    task automatic ok_load(input string nm, input logic [5:0] op, input logic [31:0] addr,
                           input logic [4:0] rd, input logic [31:0] rdata,
                           input logic [31:0] exp_addr, input logic [31:0] exp_data);
        expect_rsp(exp_data, rd, 2'd0);
        issue(op, addr, rd);
        check({nm, "_strobe_t1"}, 64'(mem_rd_en), 64'd1);
        check({nm, "_mem_addr"}, 64'(mem_addr), 64'(exp_addr));
        tick();
        check({nm, "_strobe_t2"}, 64'(mem_rd_en), 64'd0);
        mem_rvalid = 1'b1;
        mem_rdata  = rdata;
        tick();
        mem_rvalid = 1'b0;
        mem_rdata  = '0;
        check({nm, "_rsp_valid_t3"}, 64'(rsp_valid), 64'd1);
        tick();
        check({nm, "_rsp_drop"}, 64'(rsp_valid), 64'd0);
    endtask

    task automatic err_load(input string nm, input logic [5:0] op, input logic [31:0] addr,
                            input logic [4:0] rd, input logic [1:0] code);
        expect_rsp(32'd0, rd, code);
        issue(op, addr, rd);
        check({nm, "_rsp_valid_t1"}, 64'(rsp_valid), 64'd1);
        check({nm, "_no_strobe"}, 64'(mem_rd_en), 64'd0);
        tick();
        check({nm, "_rsp_drop"}, 64'(rsp_valid), 64'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int k;
        repeat (3) tick();
        reset = 1'b0;
        tick();
        check("rst_req_ready", 64'(req_ready), 64'd1);
        check("rst_mem_rd_en", 64'(mem_rd_en), 64'd0);
        check("rst_mem_addr", 64'(mem_addr), 64'd0);
        check("rst_rsp_valid", 64'(rsp_valid), 64'd0);
        check("rst_rsp_data", 64'(rsp_data), 64'd0);
        check("rst_rsp_rd", 64'(rsp_rd), 64'd0);
        check("rst_rsp_err", 64'(rsp_err), 64'd0);
        check("rst_rsp_code", 64'(rsp_err_code), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);

        ok_load("lb",  6'b100000, 32'h1003, 5'd3,  32'h8011_2233, 32'h1000, 32'hFFFF_FF80);
        ok_load("lhu", 6'b100101, 32'h2002, 5'd5,  32'hBEEF_1234, 32'h2000, 32'h0000_BEEF);
        ok_load("lh",  6'b100001, 32'h2002, 5'd6,  32'hBEEF_1234, 32'h2000, 32'hFFFF_BEEF);
        ok_load("lbu", 6'b100100, 32'h1001, 5'd8,  32'h8011_2233, 32'h1000, 32'h0000_0022);
        ok_load("lw",  6'b100011, 32'h3000, 5'd10, 32'h89AB_CDEF, 32'h3000, 32'h89AB_CDEF);
        ok_load("lh0", 6'b100001, 32'h3000, 5'd11, 32'h1234_8001, 32'h3000, 32'hFFFF_8001);

        err_load("ld32", 6'b110111, 32'h7000, 5'd4, 2'd3);

`ifdef LOAD_UNALIGNED_SPLIT_EN
        expect_rsp(32'h5544_3322, 5'd2, 2'd0);
        issue(6'b100011, 32'h0001, 5'd2);
        check("split_strobe1", 64'(mem_rd_en), 64'd1);
        check("split_addr1", 64'(mem_addr), 64'h0);
        tick();
        mem_rvalid = 1'b1;
        mem_rdata  = 32'h4433_2211;
        tick();
        mem_rvalid = 1'b0;
        check("split_strobe2", 64'(mem_rd_en), 64'd1);
        check("split_addr2", 64'(mem_addr), 64'h4);
        tick();
        mem_rvalid = 1'b1;
        mem_rdata  = 32'h8877_6655;
        tick();
        mem_rvalid = 1'b0;
        check("split_rsp_valid", 64'(rsp_valid), 64'd1);
        tick();
`else
        err_load("lw_mis", 6'b100011, 32'h0001, 5'd2, 2'd1);
        err_load("lh_mis", 6'b100001, 32'h2001, 5'd13, 2'd1);
`endif

        // Timeout: four empty WAIT cycles, then a stray late rvalid.
        expect_rsp(32'd0, 5'd7, 2'd2);
        issue(6'b100011, 32'h4000, 5'd7);
        check("tmo_strobe", 64'(mem_rd_en), 64'd1);
        k = 0;
        while (!rsp_valid && k < 20) begin
            tick();
            k++;
        end
        check("tmo_latency", 64'(k), 64'd5);
        tick();
        mem_rvalid = 1'b1;
        mem_rdata  = 32'hDEAD_BEEF;
        tick();
        mem_rvalid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("tmo_stray_no_rsp", 64'(rsp_valid), 64'd0);
        end
        check("tmo_stray_idle", 64'(busy), 64'd0);

        // Illegal opcode while the consumer stalls.
        rsp_ready = 1'b0;
        expect_rsp(32'd0, 5'd12, 2'd3);
        issue(6'b101011, 32'h6000, 5'd12);
        check("ill_rsp_valid", 64'(rsp_valid), 64'd1);
        check("ill_no_strobe", 64'(mem_rd_en), 64'd0);
        for (int i = 0; i < 5; i++) begin
            tick();
            check("stall_valid", 64'(rsp_valid), 64'd1);
            check("stall_code", 64'(rsp_err_code), 64'd3);
            check("stall_rd", 64'(rsp_rd), 64'd12);
            check("stall_data", 64'(rsp_data), 64'd0);
            check("stall_req_ready", 64'(req_ready), 64'd0);
        end
        rsp_ready = 1'b1;
        tick();
        check("stall_release", 64'(rsp_valid), 64'd0);
        check("stall_ready_back", 64'(req_ready), 64'd1);

        // Reset during WAIT, then a memory response that must be dropped.
        issue(6'b100011, 32'h5000, 5'd9);
        tick();
        check("rstw_in_wait", 64'(busy), 64'd1);
        reset = 1'b1;
        tick();
        check("rstw_busy", 64'(busy), 64'd0);
        check("rstw_mem_addr", 64'(mem_addr), 64'd0);
        reset = 1'b0;
        mem_rvalid = 1'b1;
        mem_rdata  = 32'h1234_5678;
        tick();
        mem_rvalid = 1'b0;
        tick();
        check("rstw_rsp_valid", 64'(rsp_valid), 64'd0);
        check("rstw_req_ready", 64'(req_ready), 64'd1);
        check("rstw_rsp_data", 64'(rsp_data), 64'd0);
        check("rstw_rsp_rd", 64'(rsp_rd), 64'd0);
        check("rstw_rsp_code", 64'(rsp_err_code), 64'd0);
        check("rstw_mem_rd_en", 64'(mem_rd_en), 64'd0);

        repeat (3) tick();
        check("queue_drained", 64'(exp_q.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/load_access_unit.md
Name: load_access_unit

Overview:
- Parametrised MEM-stage load engine; successor to the combinational load-type extender.
- Accepts one load request, issues an aligned memory read, waits a variable number of cycles for data, then selects the byte lane and sign/zero-extends.
- Returns the result with the destination register tag; flags misaligned, illegal and timed-out accesses.
- Sits between the EX/MEM pipeline register and the data-memory port; stalls the pipeline through its ready/valid handshake.

Parameters:
- DATA_W, 32, memory word and result width; 32 or 64 only.
- ADDR_W, 32, byte address width.
- TIMEOUT_CYCLES, 255, maximum cycles in WAIT before a timeout error; at least 1.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous active-high reset.
- req_valid  in  1  load request present.
- req_ready  out  1  unit can accept a request.
- req_op  in  6  MIPS load opcode.
- req_addr  in  ADDR_W  byte address.
- req_rd  in  5  destination register tag.
- mem_rd_en  out  1  one-cycle read strobe.
- mem_addr  out  ADDR_W  word-aligned read address (low log2(DATA_W/8) bits are 0).
- mem_rdata  in  DATA_W  read data.
- mem_rvalid  in  1  read data valid.
- rsp_valid  out  1  result available.
- rsp_ready  in  1  consumer takes the result.
- rsp_data  out  DATA_W  extended load result.
- rsp_rd  out  5  tag echoed from the request.
- rsp_err  out  1  error flag.
- rsp_err_code  out  2  error code: 0 none, 1 misaligned, 2 timeout, 3 illegal opcode.
- busy  out  1  state is not IDLE.

Behaviour:
- Interface: one clock, clk; reset is synchronous and active-high, port named reset.
- Reset: state IDLE; req_ready=1; mem_rd_en=0; mem_addr=0; rsp_valid=0; rsp_data=0; rsp_rd=0; rsp_err=0; rsp_err_code=0; busy=0; timeout counter=0.
- Opcodes:
  - LB 100000 sign; LH 100001 sign; LW 100011 sign (full word when DATA_W=32).
  - LBU 100100 zero; LHU 100101 zero; LWU 100111 zero.
  - LD 110111 is legal only when DATA_W=64.
  - Any other opcode, or LD when DATA_W=32, is illegal (code 3).
- Lane select is little-endian: byte k = bits 8k+7:8k of the word, k = req_addr[log2(DATA_W/8)-1:0].
- Sign extension replicates the top bit of the selected field across all upper bits. A halfword 0x8001 yields 0xFFFF8001.
- States: IDLE, ISSUE, WAIT, ISSUE2, WAIT2, RESP. ISSUE2 and WAIT2 exist only with the optional feature.
- IDLE: req_ready=1. On req_valid, capture op, addr and rd.
  - Illegal opcode -> RESP with code 3; no memory access.
  - Misaligned (address not a multiple of the access size) -> RESP with code 1; no memory access.
  - Otherwise -> ISSUE.
- ISSUE: mem_rd_en=1 for exactly one cycle; mem_addr = addr with low bits cleared -> WAIT.
- WAIT: mem_rvalid is sampled starting the cycle after mem_rd_en.
  - On mem_rvalid: extract and extend, register into rsp_data -> RESP.
  - Counter increments every WAIT cycle. If it reaches TIMEOUT_CYCLES without mem_rvalid -> RESP with code 2 and rsp_data=0.
  - Counter clears on leaving WAIT.
- RESP: rsp_valid=1; all rsp_* outputs held stable until rsp_ready. On rsp_valid&&rsp_ready -> IDLE; rsp_valid drops the next cycle.
  - No back-to-back acceptance: req_ready=0 in every state except IDLE.
- Minimum latency: accept at T, mem_rd_en at T+1, mem_rvalid at T+2, rsp_valid at T+3. Error cases give rsp_valid at T+1.
- mem_rvalid arriving outside WAIT/WAIT2 is ignored. This covers late responses after a timeout or after reset.
- Reset asserted mid-operation returns to IDLE with all outputs at reset values the next edge; any pending memory response is dropped.
- rsp_err=1 exactly when rsp_err_code≠0.

Optional Feature:
- Macro: LOAD_UNALIGNED_SPLIT_EN.
- Defined:
  - Misaligned accesses are legal (code 1 never raised).
  - An access contained in one word uses a single read.
  - An access crossing a word boundary goes ISSUE -> WAIT -> ISSUE2 -> WAIT2.
  - The second read is at the aligned address + DATA_W/8, wrapping modulo 2^ADDR_W with no error.
  - Bytes are merged little-endian, then extended.
  - The timeout counter restarts in WAIT2; a timeout in either wait gives code 2.
- Undefined: any non-natural alignment gives code 1. ISSUE2/WAIT2 and the merge logic are absent.

Decomposition:
- Package load_pkg:
  - opcode constants.
  - error-code constants.
  - state enum typedef.
  - access-size function (op -> bytes).
- One sub-module, load_extract: combinational. Inputs: word (or 2×word merged), byte offset, op. Output: extended DATA_W result. Reused for single and split paths.

Test Plan:
- LB at addr 0x1003, mem_rdata=0x80112233, rvalid 1 cycle after strobe -> mem_addr=0x1000, rsp_data=0xFFFFFF80, err=0, rsp_valid at T+3.
- LHU at addr 0x2002, rdata=0xBEEF1234 -> rsp_data=0x0000BEEF. LH same address -> 0xFFFFBEEF.
- LW at addr 0x0001, feature off -> no mem_rd_en, rsp_err_code=1 at T+1. Feature on, words 0x44332211 then 0x88776655 -> two reads (0x0000, 0x0004), rsp_data=0x55443322.
- LW with mem_rvalid never asserted, TIMEOUT_CYCLES=4 -> rsp_err_code=2, rsp_data=0. A later stray rvalid causes no response.
- Opcode 101011 -> code 3, no strobe. rsp_ready held low 5 cycles -> rsp_* stable, req_ready=0 throughout.
- Reset pulsed during WAIT, then rvalid arrives -> outputs at reset values, rsp_valid stays 0, req_ready=1.
